dpram_access_ctrl: RTL and testbench
====================================

# dpram_access_ctrl

Initiator-side controller for the two-port synchronous RAM (`we/oe/addr/d_in/d_out` per port, registered reads, port-2 write dropped on address match with port 1). Accepts two independent valid/ready request streams, drives the RAM port pins from registers, and returns read data with a `rsp_valid` strobe. It sits between client logic and the RAM and resolves same-cycle write/write address collisions by stalling port 2, so no write is ever silently lost.

## Interface
- `DATA_WIDTH`, 2: RAM word width.
- `ADDR_WIDTH`, 4: RAM address width.
- `clk` in 1: sole clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req1_valid` / `req2_valid` in 1: request present on port 1 / port 2.
- `req1_ready` / `req2_ready` out 1: request accepted at this edge when valid && ready.
- `req1_write` / `req2_write` in 1: 1 = write, 0 = read.
- `req1_addr` / `req2_addr` in ADDR_WIDTH: request address.
- `req1_wdata` / `req2_wdata` in DATA_WIDTH: write data.
- `rsp1_valid` / `rsp2_valid` out 1: one-cycle strobe, read data valid.
- `rsp1_rdata` / `rsp2_rdata` out DATA_WIDTH: read data.
- `ram_we1`, `ram_oe1`, `ram_addr1`, `ram_d_in1` out: drive RAM port 1 (`ram_we2`… likewise for port 2).
- `ram_d_out1` / `ram_d_out2` in DATA_WIDTH: RAM registered read data.
- `stall_cnt` out 16: present only with `DPM_STALL_CNT_EN`.

## Operation
- `req1_ready` is constantly 1 outside reset; port 1 never stalls.
- `req2_ready` = 0 when `req1_valid && req1_write && req2_valid && req2_write && req1_addr == req2_addr`, else 1 (combinational).
- Accepted request registers onto the RAM pins: write → `we=1, oe=0, addr, d_in=wdata`; read → `we=0, oe=1, addr`, `d_in` held. No acceptance → `we=0, oe=0`.
- Per-port response pipeline: a 1-bit "read issued" flag follows the RAM pin stage; the following cycle `rsp_rdata <= ram_d_out`, `rsp_valid <= 1`.
- Writes produce no response.
- Port 1 write and port 2 read (or vice versa) to the same address in the same cycle are allowed; the read returns the pre-write contents.
- Same-address reads on both ports are allowed; both return identical data.
- Per port, responses return in request order; throughput is 1 request per cycle per port.

## Timing
- Reset (`rst_n=0` at an edge): all `ram_we*`, `ram_oe*`, `ram_addr*`, `ram_d_in*`, `rsp*_valid`, `rsp*_rdata` and `stall_cnt` become 0; `req*_ready` = 0 while `rst_n=0`.
- Reset mid-operation: in-flight reads are discarded; no `rsp_valid` is issued for them.
- Read latency: request accepted at edge T → RAM pins valid after T → RAM samples at T+1 → `rsp_valid=1` after T+2 for exactly one cycle (2 edges).
- Write: pins valid after T; memory updated at edge T+1.
- A stalled port-2 write is accepted on the next edge where the collision condition is false; its RAM pins follow one cycle later.
- Back-to-back reads give `rsp_valid` high on consecutive cycles.

## Configuration
- `DPM_STALL_CNT_EN` defined: `stall_cnt` port exists; it increments by 1 on every edge where `req2_valid && !req2_ready` (reset excluded), saturates at 16'hFFFF, and clears on reset.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then port-1 write addr 4'h3 data 2'b10 and a port-1 read of 4'h3 two cycles later → `rsp1_valid` 2 cycles after the read accept with `rsp1_rdata=2'b10`.
- Same-cycle writes, both to addr 4'h5, port 1 data 2'b01 and port 2 data 2'b11 → `req2_ready=0` for 1 cycle; mem[5] reads 2'b11 afterwards; `stall_cnt=1` with the macro defined.
- Port 1 writes 4'h7=2'b11 while port 2 reads 4'h7 (previously 2'b00) → `rsp2_rdata=2'b00`; a later read returns 2'b11.
- Port-2 reads on 4 consecutive cycles, addresses 0..3 preloaded with 0,1,2,3 → `rsp2_valid` high 4 consecutive cycles, data 0,1,2,3 in order.
- Read accepted, then `rst_n=0` on the next edge → `rsp1_valid` stays 0 and all RAM pins are 0.
- Continuous same-address write collisions for 70000 cycles → `stall_cnt` saturates at 16'hFFFF.

Source files
------------

// File: rtl/dpram_access_ctrl.sv
// Initiator-side controller for a two-port synchronous RAM: registered pin drive,
// read-response pipeline, port-2 stall on write/write address collision. Optional DPM_STALL_CNT_EN.
module dpram_access_ctrl #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic                  req2_valid,
  output logic                  req2_ready,
  input  logic                  req2_write,
  input  logic [ADDR_WIDTH-1:0] req2_addr,
  input  logic [DATA_WIDTH-1:0] req2_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp2_valid,
  output logic [DATA_WIDTH-1:0] rsp2_rdata,
  output logic                  ram_we1,
  output logic                  ram_oe1,
  output logic [ADDR_WIDTH-1:0] ram_addr1,
  output logic [DATA_WIDTH-1:0] ram_d_in1,
  input  logic [DATA_WIDTH-1:0] ram_d_out1,
  output logic                  ram_we2,
  output logic                  ram_oe2,
  output logic [ADDR_WIDTH-1:0] ram_addr2,
  output logic [DATA_WIDTH-1:0] ram_d_in2,
  input  logic [DATA_WIDTH-1:0] ram_d_out2
`ifdef DPM_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  logic                  w_collide, w_acc1, w_acc2;
  logic                  r_we1, r_oe1, r_rd1, r_rsp_v1;
  logic                  r_we2, r_oe2, r_rd2, r_rsp_v2;
  logic [ADDR_WIDTH-1:0] r_addr1, r_addr2;
  logic [DATA_WIDTH-1:0] r_din1, r_din2, r_rsp_d1, r_rsp_d2;

  // The RAM drops a port-2 write on address match, so hold port 2 back instead.
  assign w_collide  = req1_valid & req1_write & req2_valid & req2_write & (req1_addr == req2_addr);
  assign req1_ready = rst_n;
  assign req2_ready = rst_n & ~w_collide;
  assign w_acc1     = req1_valid & req1_ready;
  assign w_acc2     = req2_valid & req2_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we1    <= 1'b0;
      r_oe1    <= 1'b0;
      r_addr1  <= '0;
      r_din1   <= '0;
      r_rd1    <= 1'b0;
      r_rsp_v1 <= 1'b0;
      r_rsp_d1 <= '0;
    end else begin
      r_we1 <= w_acc1 & req1_write;
      r_oe1 <= w_acc1 & ~req1_write;
      if (w_acc1) r_addr1 <= req1_addr;
      if (w_acc1 && req1_write) r_din1 <= req1_wdata;
      r_rd1    <= r_oe1;
      r_rsp_v1 <= r_rd1;
      if (r_rd1) r_rsp_d1 <= ram_d_out1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we2    <= 1'b0;
      r_oe2    <= 1'b0;
      r_addr2  <= '0;
      r_din2   <= '0;
      r_rd2    <= 1'b0;
      r_rsp_v2 <= 1'b0;
      r_rsp_d2 <= '0;
    end else begin
      r_we2 <= w_acc2 & req2_write;
      r_oe2 <= w_acc2 & ~req2_write;
      if (w_acc2) r_addr2 <= req2_addr;
      if (w_acc2 && req2_write) r_din2 <= req2_wdata;
      r_rd2    <= r_oe2;
      r_rsp_v2 <= r_rd2;
      if (r_rd2) r_rsp_d2 <= ram_d_out2;
    end
  end

  assign ram_we1    = r_we1;
  assign ram_oe1    = r_oe1;
  assign ram_addr1  = r_addr1;
  assign ram_d_in1  = r_din1;
  assign ram_we2    = r_we2;
  assign ram_oe2    = r_oe2;
  assign ram_addr2  = r_addr2;
  assign ram_d_in2  = r_din2;
  assign rsp1_valid = r_rsp_v1;
  assign rsp1_rdata = r_rsp_d1;
  assign rsp2_valid = r_rsp_v2;
  assign rsp2_rdata = r_rsp_d2;

`ifdef DPM_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (req2_valid && !req2_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Directed self-checking bench for dpram_access_ctrl with a behavioural two-port RAM.
module tb_dpram_access_ctrl;

  logic       clk, rst_n;
  logic       req1_valid, req1_ready, req1_write;
  logic [3:0] req1_addr;
  logic [1:0] req1_wdata;
  logic       req2_valid, req2_ready, req2_write;
  logic [3:0] req2_addr;
  logic [1:0] req2_wdata;
  logic       rsp1_valid, rsp2_valid;
  logic [1:0] rsp1_rdata, rsp2_rdata;
  logic       ram_we1, ram_oe1, ram_we2, ram_oe2;
  logic [3:0] ram_addr1, ram_addr2;
  logic [1:0] ram_d_in1, ram_d_in2, ram_d_out1, ram_d_out2;
`ifdef DPM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  dpram_access_ctrl #(.DATA_WIDTH(2), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req2_valid(req2_valid), .req2_ready(req2_ready), .req2_write(req2_write),
    .req2_addr(req2_addr), .req2_wdata(req2_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp2_valid(rsp2_valid), .rsp2_rdata(rsp2_rdata),
    .ram_we1(ram_we1), .ram_oe1(ram_oe1), .ram_addr1(ram_addr1),
    .ram_d_in1(ram_d_in1), .ram_d_out1(ram_d_out1),
    .ram_we2(ram_we2), .ram_oe2(ram_oe2), .ram_addr2(ram_addr2),
    .ram_d_in2(ram_d_in2), .ram_d_out2(ram_d_out2)
`ifdef DPM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Two-port RAM: registered reads, port-2 write dropped when port 1 writes the same address.
  logic [1:0] mem [16];
  always @(posedge clk) begin
    if (ram_oe1) ram_d_out1 <= mem[ram_addr1];
    if (ram_oe2) ram_d_out2 <= mem[ram_addr2];
    if (ram_we1) mem[ram_addr1] <= ram_d_in1;
    if (ram_we2 && !(ram_we1 && ram_addr1 == ram_addr2)) mem[ram_addr2] <= ram_d_in2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    req2_valid = 1'b0; req2_write = 1'b0; req2_addr = '0; req2_wdata = '0;
  endtask

  task automatic set1(input logic wr, input logic [3:0] a, input logic [1:0] d);
    req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = d;
  endtask

  task automatic set2(input logic wr, input logic [3:0] a, input logic [1:0] d);
    req2_valid = 1'b1; req2_write = wr; req2_addr = a; req2_wdata = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick(); tick();
    n_cmp++;
    if ({ram_we1, ram_oe1, ram_addr1, ram_d_in1, ram_we2, ram_oe2, ram_addr2, ram_d_in2} !== 16'h0) begin
      n_bad++; $display("FAIL reset_pins: got %h required 0000",
        {ram_we1, ram_oe1, ram_addr1, ram_d_in1, ram_we2, ram_oe2, ram_addr2, ram_d_in2});
    end
    n_cmp++;
    if ({rsp1_valid, rsp1_rdata, rsp2_valid, rsp2_rdata} !== 6'h0) begin
      n_bad++; $display("FAIL reset_rsp: got %h required 00", {rsp1_valid, rsp1_rdata, rsp2_valid, rsp2_rdata});
    end
    req1_valid = 1'b1; req2_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req1_ready, req2_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ready: got %b required 00", {req1_ready, req2_ready});
    end
`ifdef DPM_STALL_CNT_EN
    n_cmp++;
    if (stall_cnt !== 16'h0) begin
      n_bad++; $display("FAIL reset_stall_cnt: got %h required 0000", stall_cnt);
    end
`endif
    idle();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({req1_ready, req2_ready} !== 2'b11) begin
      n_bad++; $display("FAIL ready_after_reset: got %b required 11", {req1_ready, req2_ready});
    end
  endtask

  task automatic test_write_read();
    set1(1'b1, 4'h3, 2'b10);
    tick();
    n_cmp++;
    if ({ram_we1, ram_oe1, ram_addr1, ram_d_in1} !== {1'b1, 1'b0, 4'h3, 2'b10}) begin
      n_bad++; $display("FAIL wr_pins: got %h required %h", {ram_we1, ram_oe1, ram_addr1, ram_d_in1}, {1'b1, 1'b0, 4'h3, 2'b10});
    end
    idle();
    tick();
    n_cmp++;
    if ({ram_we1, ram_oe1} !== 2'b00) begin
      n_bad++; $display("FAIL idle_pins: got %b required 00", {ram_we1, ram_oe1});
    end
    set1(1'b0, 4'h3, 2'b00);
    tick();
    n_cmp++;
    if ({ram_we1, ram_oe1, ram_addr1, ram_d_in1} !== {1'b0, 1'b1, 4'h3, 2'b10}) begin
      n_bad++; $display("FAIL rd_pins: got %h required %h", {ram_we1, ram_oe1, ram_addr1, ram_d_in1}, {1'b0, 1'b1, 4'h3, 2'b10});
    end
    idle();
    tick();
    n_cmp++;
    if (rsp1_valid !== 1'b0) begin
      n_bad++; $display("FAIL rd_early_valid: got %b required 0", rsp1_valid);
    end
    tick();
    n_cmp++;
    if ({rsp1_valid, rsp1_rdata} !== 3'b1_10) begin
      n_bad++; $display("FAIL rd_rsp: got %b required 110", {rsp1_valid, rsp1_rdata});
    end
    tick();
    n_cmp++;
    if (rsp1_valid !== 1'b0) begin
      n_bad++; $display("FAIL rd_strobe_width: got %b required 0", rsp1_valid);
    end
  endtask

  task automatic test_collision();
    set1(1'b1, 4'h5, 2'b01);
    set2(1'b1, 4'h6, 2'b11);
    #1;
    n_cmp++;
    if (req2_ready !== 1'b1) begin
      n_bad++; $display("FAIL diff_addr_ready: got %b required 1", req2_ready);
    end
    set1(1'b0, 4'h5, 2'b01);
    set2(1'b1, 4'h5, 2'b11);
    #1;
    n_cmp++;
    if (req2_ready !== 1'b1) begin
      n_bad++; $display("FAIL rd_wr_ready: got %b required 1", req2_ready);
    end
    set1(1'b1, 4'h5, 2'b01);
    #1;
    n_cmp++;
    if ({req1_ready, req2_ready} !== 2'b10) begin
      n_bad++; $display("FAIL coll_ready: got %b required 10", {req1_ready, req2_ready});
    end
    tick();
    req1_valid = 1'b0;
    #1;
    n_cmp++;
    if (req2_ready !== 1'b1) begin
      n_bad++; $display("FAIL coll_release: got %b required 1", req2_ready);
    end
    n_cmp++;
    if ({ram_we1, ram_we2, ram_addr1} !== {1'b1, 1'b0, 4'h5}) begin
      n_bad++; $display("FAIL coll_p1_pins: got %h required %h", {ram_we1, ram_we2, ram_addr1}, {1'b1, 1'b0, 4'h5});
    end
    tick();
    n_cmp++;
    if ({ram_we1, ram_we2, ram_addr2, ram_d_in2} !== {1'b0, 1'b1, 4'h5, 2'b11}) begin
      n_bad++; $display("FAIL coll_p2_pins: got %h required %h", {ram_we1, ram_we2, ram_addr2, ram_d_in2}, {1'b0, 1'b1, 4'h5, 2'b11});
    end
    idle();
    tick();
    set1(1'b0, 4'h5, 2'b00);
    tick();
    idle();
    tick(); tick();
    n_cmp++;
    if ({rsp1_valid, rsp1_rdata} !== 3'b1_11) begin
      n_bad++; $display("FAIL coll_readback: got %b required 111", {rsp1_valid, rsp1_rdata});
    end
`ifdef DPM_STALL_CNT_EN
    n_cmp++;
    if (stall_cnt !== 16'd1) begin
      n_bad++; $display("FAIL coll_stall_cnt: got %0d required 1", stall_cnt);
    end
`endif
  endtask

  task automatic test_rw_same_addr();
    set1(1'b1, 4'h7, 2'b11);
    set2(1'b0, 4'h7, 2'b00);
    tick();
    idle();
    tick(); tick();
    n_cmp++;
    if ({rsp2_valid, rsp2_rdata} !== 3'b1_00) begin
      n_bad++; $display("FAIL rw_old_data: got %b required 100", {rsp2_valid, rsp2_rdata});
    end
    set2(1'b0, 4'h7, 2'b00);
    tick();
    idle();
    tick(); tick();
    n_cmp++;
    if ({rsp2_valid, rsp2_rdata} !== 3'b1_11) begin
      n_bad++; $display("FAIL rw_new_data: got %b required 111", {rsp2_valid, rsp2_rdata});
    end
    set1(1'b0, 4'h7, 2'b00);
    set2(1'b0, 4'h7, 2'b00);
    tick();
    idle();
    tick(); tick();
    n_cmp++;
    if ({rsp1_valid, rsp1_rdata, rsp2_valid, rsp2_rdata} !== 6'b111_111) begin
      n_bad++; $display("FAIL dual_read: got %b required 111111", {rsp1_valid, rsp1_rdata, rsp2_valid, rsp2_rdata});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_d;
    logic       exp_v;
    for (int unsigned i = 0; i < 4; i++) begin
      set1(1'b1, 4'(i), 2'(i));
      tick();
    end
    idle();
    tick();
    for (int unsigned t = 0; t < 7; t++) begin
      if (t < 4) set2(1'b0, 4'(t), 2'b00);
      else idle();
      tick();
      exp_v = (t >= 2 && t <= 5);
      exp_d = 2'(t - 2);
      n_cmp++;
      if (rsp2_valid !== exp_v) begin
        n_bad++; $display("FAIL b2b_valid[%0d]: got %b required %b", t, rsp2_valid, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (rsp2_rdata !== exp_d) begin
          n_bad++; $display("FAIL b2b_data[%0d]: got %0d required %0d", t, rsp2_rdata, exp_d);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set1(1'b0, 4'h3, 2'b00);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({ram_we1, ram_oe1, ram_addr1, ram_d_in1, ram_we2, ram_oe2, ram_addr2, ram_d_in2} !== 16'h0) begin
      n_bad++; $display("FAIL mid_reset_pins: got %h required 0000",
        {ram_we1, ram_oe1, ram_addr1, ram_d_in1, ram_we2, ram_oe2, ram_addr2, ram_d_in2});
    end
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (rsp1_valid !== 1'b0) begin
        n_bad++; $display("FAIL mid_reset_rsp[%0d]: got %b required 0", k, rsp1_valid);
      end
    end
  endtask

`ifdef DPM_STALL_CNT_EN
  task automatic test_stall_saturate();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (stall_cnt !== 16'h0) begin
      n_bad++; $display("FAIL sat_clear: got %h required 0000", stall_cnt);
    end
    set1(1'b1, 4'h9, 2'b01);
    set2(1'b1, 4'h9, 2'b10);
    repeat (65534) tick();
    n_cmp++;
    if (stall_cnt !== 16'hFFFE) begin
      n_bad++; $display("FAIL sat_pre: got %h required fffe", stall_cnt);
    end
    repeat (70000 - 65534) tick();
    n_cmp++;
    if (stall_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL sat_hold: got %h required ffff", stall_cnt);
    end
    idle();
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'b00;
    ram_d_out1 = 2'b00;
    ram_d_out2 = 2'b00;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_collision();
    test_rw_same_addr();
    test_back_to_back();
    test_reset_mid();
`ifdef DPM_STALL_CNT_EN
    test_stall_saturate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
